// File: rtl/frame_burst_master_if.sv
// Burst/FIFO bundle between frame_burst_master, the camera/VGA FIFOs and the DDR3 controller.
interface frame_burst_master_if #(
  parameter int unsigned MEM_DATA_BITS = 64
);
  // Write FIFO (FWFT) side
  logic [9:0]               wr_fifo_count;
  logic [MEM_DATA_BITS-1:0] wr_fifo_dout;
  logic                     wr_fifo_rd_en;
  // Read FIFO side
  logic [9:0]               rd_fifo_space;
  logic                     rd_fifo_wr_en;
  logic [MEM_DATA_BITS-1:0] rd_fifo_din;
  // Controller write burst port
  logic                     wr_burst_req;
  logic [9:0]               wr_burst_len;
  logic [23:0]              wr_burst_addr;
  logic                     wr_burst_data_req;
  logic [MEM_DATA_BITS-1:0] wr_burst_data;
  logic                     wr_burst_finish;
  // Controller read burst port
  logic                     rd_burst_req;
  logic [9:0]               rd_burst_len;
  logic [23:0]              rd_burst_addr;
  logic                     rd_burst_data_valid;
  logic [MEM_DATA_BITS-1:0] rd_burst_data;
  logic                     rd_burst_finish;

  modport master (
    input  wr_fifo_count, wr_fifo_dout, rd_fifo_space,
    input  wr_burst_data_req, wr_burst_finish,
    input  rd_burst_data_valid, rd_burst_data, rd_burst_finish,
    output wr_fifo_rd_en, rd_fifo_wr_en, rd_fifo_din,
    output wr_burst_req, wr_burst_len, wr_burst_addr, wr_burst_data,
    output rd_burst_req, rd_burst_len, rd_burst_addr
  );

  modport slave (
    output wr_fifo_count, wr_fifo_dout, rd_fifo_space,
    output wr_burst_data_req, wr_burst_finish,
    output rd_burst_data_valid, rd_burst_data, rd_burst_finish,
    input  wr_fifo_rd_en, rd_fifo_wr_en, rd_fifo_din,
    input  wr_burst_req, wr_burst_len, wr_burst_addr, wr_burst_data,
    input  rd_burst_req, rd_burst_len, rd_burst_addr
  );
endinterface

// File: rtl/frame_burst_master.sv
// Round-robin DDR3 burst initiator: drains the video write FIFO into a circular
// frame region and refills the display read FIFO from another, with frame-sync restart.
module frame_burst_master #(
  parameter int unsigned MEM_DATA_BITS = 64,
  parameter int unsigned BURST_LEN     = 64,
  parameter int unsigned FRAME_BURSTS  = 600,
  parameter int unsigned ADDR_STEP     = 512,
  parameter logic [23:0] WR_BASE       = 24'h0,
  parameter logic [23:0] RD_BASE       = 24'h0
) (
  input  logic                 mem_clk,
  input  logic                 rst,
  input  logic                 calib_done,
  input  logic                 wr_frame_sync,
  input  logic                 rd_frame_sync,
  frame_burst_master_if.master bus,
  output logic                 busy,
  output logic                 len_err
);

  localparam int unsigned LEN_W  = 10;
  localparam int unsigned ADDR_W = 24;
  localparam int unsigned CNT_W  = $clog2(FRAME_BURSTS + 1);

  localparam logic [LEN_W-1:0]  LEN_V    = LEN_W'(BURST_LEN);
  localparam logic [LEN_W-1:0]  WORD_MAX = '1;
  localparam logic [ADDR_W-1:0] STEP_V   = ADDR_W'(ADDR_STEP);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(FRAME_BURSTS - 1);

  typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST} state_t;
  typedef enum logic {GNT_WR, GNT_RD} grant_t;

  state_t              state;
  grant_t              last_grant;
  logic [ADDR_W-1:0]   wr_addr;
  logic [ADDR_W-1:0]   rd_addr;
  logic [CNT_W-1:0]    wr_cnt;
  logic [CNT_W-1:0]    rd_cnt;
  logic                wr_sync_pend;
  logic                rd_sync_pend;
  logic                wr_req;
  logic                rd_req;
  logic [LEN_W-1:0]    wr_words;
  logic [LEN_W-1:0]    rd_words;

  logic                wr_ok_c;
  logic                rd_ok_c;
  logic                grant_wr_c;
  logic                grant_rd_c;
  logic [LEN_W-1:0]    wr_words_c;
  logic [LEN_W-1:0]    rd_words_c;
  logic [MEM_DATA_BITS-1:0] wr_data_c;
  logic [MEM_DATA_BITS-1:0] rd_data_c;

  // Round-robin arbitration: on a tie the side not served last wins
  always_comb begin
    wr_ok_c    = calib_done && (bus.wr_fifo_count >= LEN_V);
    rd_ok_c    = calib_done && (bus.rd_fifo_space >= LEN_V);
    grant_wr_c = wr_ok_c && (!rd_ok_c || (last_grant == GNT_RD));
    grant_rd_c = rd_ok_c && !grant_wr_c;
  end

  // Saturating per-burst word counts, including a beat in the current cycle
  always_comb begin
    wr_words_c = wr_words;
    rd_words_c = rd_words;
    if (bus.wr_burst_data_req && (wr_words != WORD_MAX)) wr_words_c = wr_words + LEN_W'(1);
    if (bus.rd_burst_data_valid && (rd_words != WORD_MAX)) rd_words_c = rd_words + LEN_W'(1);
  end

  // Burst sequencer, address/frame counters, sync handling and error flag
  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      last_grant   <= GNT_RD;
      wr_addr      <= WR_BASE;
      rd_addr      <= RD_BASE;
      wr_cnt       <= '0;
      rd_cnt       <= '0;
      wr_sync_pend <= 1'b0;
      rd_sync_pend <= 1'b0;
      wr_req       <= 1'b0;
      rd_req       <= 1'b0;
      wr_words     <= '0;
      rd_words     <= '0;
      busy         <= 1'b0;
      len_err      <= 1'b0;
    end else begin
      if (wr_frame_sync) wr_sync_pend <= 1'b1;
      if (rd_frame_sync) rd_sync_pend <= 1'b1;

      case (state)
        IDLE: begin
          if (wr_sync_pend || rd_sync_pend) begin
            // Restart the frame walk; a sync landing right now stays pending
            if (wr_sync_pend) begin
              wr_addr      <= WR_BASE;
              wr_cnt       <= '0;
              wr_sync_pend <= wr_frame_sync;
            end
            if (rd_sync_pend) begin
              rd_addr      <= RD_BASE;
              rd_cnt       <= '0;
              rd_sync_pend <= rd_frame_sync;
            end
          end else if (grant_wr_c) begin
            state      <= WR_BURST;
            wr_req     <= 1'b1;
            busy       <= 1'b1;
            last_grant <= GNT_WR;
            wr_words   <= '0;
          end else if (grant_rd_c) begin
            state      <= RD_BURST;
            rd_req     <= 1'b1;
            busy       <= 1'b1;
            last_grant <= GNT_RD;
            rd_words   <= '0;
          end
        end

        WR_BURST: begin
          wr_words <= wr_words_c;
          if (bus.wr_burst_finish) begin
            state  <= IDLE;
            wr_req <= 1'b0;
            busy   <= 1'b0;
            if (wr_words_c != LEN_V) len_err <= 1'b1;
            if (wr_frame_sync || (wr_cnt == LAST_CNT)) begin
              wr_addr <= WR_BASE;
              wr_cnt  <= '0;
            end else begin
              wr_addr <= wr_addr + STEP_V;
              wr_cnt  <= wr_cnt + CNT_W'(1);
            end
          end
        end

        RD_BURST: begin
          rd_words <= rd_words_c;
          if (bus.rd_burst_finish) begin
            state  <= IDLE;
            rd_req <= 1'b0;
            busy   <= 1'b0;
            if (rd_words_c != LEN_V) len_err <= 1'b1;
            if (rd_frame_sync || (rd_cnt == LAST_CNT)) begin
              rd_addr <= RD_BASE;
              rd_cnt  <= '0;
            end else begin
              rd_addr <= rd_addr + STEP_V;
              rd_cnt  <= rd_cnt + CNT_W'(1);
            end
          end
        end

        default: begin
          state  <= IDLE;
          wr_req <= 1'b0;
          rd_req <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

  // Data paths pass straight through; FIFO strobes only while the matching burst owns the bus
  always_comb begin
    wr_data_c = bus.wr_fifo_dout;
    rd_data_c = bus.rd_burst_data;
  end

  assign bus.wr_burst_req  = wr_req;
  assign bus.wr_burst_len  = LEN_V;
  assign bus.wr_burst_addr = wr_addr;
  assign bus.wr_burst_data = wr_data_c;
  assign bus.wr_fifo_rd_en = (state == WR_BURST) && bus.wr_burst_data_req;

  assign bus.rd_burst_req  = rd_req;
  assign bus.rd_burst_len  = LEN_V;
  assign bus.rd_burst_addr = rd_addr;
  assign bus.rd_fifo_din   = rd_data_c;
  assign bus.rd_fifo_wr_en = (state == RD_BURST) && bus.rd_burst_data_valid;

endmodule

// File: tb/tb_frame_burst_master.sv
// Scoreboard bench for frame_burst_master: directed bursts, a controller model and a request monitor.
module tb_frame_burst_master;

  logic mem_clk;
  logic rst;
  logic calib_done;
  logic wr_frame_sync;
  logic rd_frame_sync;
  logic busy;
  logic len_err;

  frame_burst_master_if #(.MEM_DATA_BITS(64)) bus ();

  frame_burst_master dut (
    .mem_clk       (mem_clk),
    .rst           (rst),
    .calib_done    (calib_done),
    .wr_frame_sync (wr_frame_sync),
    .rd_frame_sync (rd_frame_sync),
    .bus           (bus),
    .busy          (busy),
    .len_err       (len_err)
  );

  initial mem_clk = 1'b0;
  always #5 mem_clk = ~mem_clk;

  typedef struct {
    bit          is_rd;
    logic [23:0] addr;
  } burst_t;

  burst_t exp_q[$];
  int errors = 0;
  int checks = 0;
  int words_cfg = 64;
  int cur_words = 64;

  function automatic logic [63:0] pat(input int i);
    return 64'hC0DE_0000_0000_0000 | 64'(i);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic push(input bit is_rd, input logic [23:0] addr);
    burst_t b;
    b.is_rd = is_rd;
    b.addr  = addr;
    exp_q.push_back(b);
  endtask

  task automatic step();
    @(posedge mem_clk);
    #1;
  endtask

  task automatic wait_q_empty(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check("expected_bursts_issued", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      step();
      n++;
    end
    check("returns_idle", 64'(busy), 64'd0);
  endtask

  // Let all queued bursts start, then starve both FIFOs and let the last one finish
  task automatic run_bursts(input int budget);
    wait_q_empty(budget);
    bus.wr_fifo_count = 10'd0;
    bus.rd_fifo_space = 10'd0;
    wait_idle(200);
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    calib_done    = 1'b0;
    wr_frame_sync = 1'b0;
    rd_frame_sync = 1'b0;
    bus.wr_fifo_count = 10'd0;
    bus.rd_fifo_space = 10'd0;
    words_cfg     = 64;
    repeat (3) step();
    rst = 1'b0;
    step();
  endtask

  // DDR3 controller model: answers each request with words_cfg beats then a finish pulse
  initial begin : ctrl
    int  phase;
    int  left;
    int  idx;
    bit  rd;
    phase = 0; left = 0; idx = 0; rd = 1'b0;
    bus.wr_burst_data_req   = 1'b0;
    bus.wr_burst_finish     = 1'b0;
    bus.rd_burst_data_valid = 1'b0;
    bus.rd_burst_finish     = 1'b0;
    bus.rd_burst_data       = 64'd0;
    bus.wr_fifo_dout        = 64'd0;
    forever begin
      @(posedge mem_clk);
      #1;
      bus.wr_burst_data_req   = 1'b0;
      bus.wr_burst_finish     = 1'b0;
      bus.rd_burst_data_valid = 1'b0;
      bus.rd_burst_finish     = 1'b0;
      bus.wr_fifo_dout        = pat(idx);
      if (rst) begin
        phase = 0;
      end else begin
        case (phase)
          0: if (bus.wr_burst_req || bus.rd_burst_req) begin
               rd        = bus.rd_burst_req;
               left      = words_cfg;
               cur_words = words_cfg;
               idx       = 0;
               bus.wr_fifo_dout = pat(0);
               phase     = 1;
             end
          1: if (left > 0) begin
               if (rd) begin
                 bus.rd_burst_data_valid = 1'b1;
                 bus.rd_burst_data       = pat(idx);
               end else begin
                 bus.wr_burst_data_req = 1'b1;
               end
               idx++;
               left--;
             end else begin
               if (rd) bus.rd_burst_finish = 1'b1;
               else    bus.wr_burst_finish = 1'b1;
               phase = 2;
             end
          default: phase = 0;
        endcase
      end
    end
  end

  // Monitor: pops the expected burst on each request rise and checks data beats and word counts
  initial begin : monitor
    logic pw;
    logic pr;
    int   wcnt;
    int   rcnt;
    burst_t e;
    pw = 1'b0; pr = 1'b0; wcnt = 0; rcnt = 0;
    forever begin
      @(negedge mem_clk);
      if (rst) begin
        pw = 1'b0; pr = 1'b0; wcnt = 0; rcnt = 0;
      end else begin
        if ((bus.wr_burst_req && !pw) || (bus.rd_burst_req && !pr)) begin
          check("single_request", 64'(bus.wr_burst_req & bus.rd_burst_req), 64'd0);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_burst: got rd=%0d addr=%0h, want none",
                     bus.rd_burst_req, bus.rd_burst_req ? bus.rd_burst_addr : bus.wr_burst_addr);
          end else begin
            e = exp_q.pop_front();
            check("burst_dir_rd", 64'(bus.rd_burst_req), 64'(e.is_rd));
            check("burst_addr", 64'(e.is_rd ? bus.rd_burst_addr : bus.wr_burst_addr), 64'(e.addr));
            check("burst_len", 64'(e.is_rd ? bus.rd_burst_len : bus.wr_burst_len), 64'd64);
          end
          wcnt = 0;
          rcnt = 0;
        end
        if (bus.wr_fifo_rd_en) begin
          check("wr_data", bus.wr_burst_data, pat(wcnt));
          wcnt++;
        end
        if (bus.rd_fifo_wr_en) begin
          check("rd_fifo_din", bus.rd_fifo_din, pat(rcnt));
          rcnt++;
        end
        if (bus.wr_burst_finish) check("wr_fifo_pops", 64'(wcnt), 64'(cur_words));
        if (bus.rd_burst_finish) check("rd_fifo_pushes", 64'(rcnt), 64'(cur_words));
        pw = bus.wr_burst_req;
        pr = bus.rd_burst_req;
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "bench timeout");
  end

  // Directed stimulus
  initial begin : stim
    logic seen;
    int   n;
    rst = 1'b1;
    calib_done = 1'b0;
    wr_frame_sync = 1'b0;
    rd_frame_sync = 1'b0;
    bus.wr_fifo_count = 10'd0;
    bus.rd_fifo_space = 10'd0;
    repeat (2) step();

    check("rst_wr_req", 64'(bus.wr_burst_req), 64'd0);
    check("rst_rd_req", 64'(bus.rd_burst_req), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_len_err", 64'(len_err), 64'd0);
    check("rst_wr_addr", 64'(bus.wr_burst_addr), 64'd0);
    check("rst_rd_addr", 64'(bus.rd_burst_addr), 64'd0);
    rst = 1'b0;
    step();

    // 1: nothing issued before calibration, then a write burst at base
    bus.wr_fifo_count = 10'd100;
    seen = 1'b0;
    repeat (6) begin
      step();
      seen = seen | bus.wr_burst_req | bus.rd_burst_req | busy;
    end
    check("no_req_before_calib", 64'(seen), 64'd0);
    push(1'b0, 24'h0);
    calib_done = 1'b1;
    n = 0;
    while (!bus.wr_burst_req && n < 6) begin
      step();
      n++;
    end
    check("req_after_calib_in_time", 64'((n >= 1) && (n <= 2)), 64'd1);
    run_bursts(100);

    // 2: both sides ready -> alternate starting with write
    do_reset();
    for (int i = 0; i < 5; i++) begin
      push(1'b0, 24'(i * 512));
      push(1'b1, 24'(i * 512));
    end
    bus.wr_fifo_count = 10'd100;
    bus.rd_fifo_space = 10'd100;
    calib_done = 1'b1;
    run_bursts(1000);
    check("len_err_clean_bursts", 64'(len_err), 64'd0);

    // 3: full frame of writes wraps back to base with the counter cleared
    do_reset();
    for (int i = 0; i < 600; i++) push(1'b0, 24'(i * 512));
    push(1'b0, 24'h0);
    push(1'b0, 24'd512);
    bus.wr_fifo_count = 10'd100;
    calib_done = 1'b1;
    run_bursts(50000);

    // 4: frame sync mid-burst keeps the in-flight address, next burst restarts at base
    do_reset();
    push(1'b0, 24'h0);
    push(1'b0, 24'd512);
    push(1'b0, 24'd1024);
    bus.wr_fifo_count = 10'd100;
    calib_done = 1'b1;
    wait_q_empty(400);
    repeat (10) step();
    wr_frame_sync = 1'b1;
    step();
    wr_frame_sync = 1'b0;
    push(1'b0, 24'h0);
    push(1'b0, 24'd512);
    step();
    check("sync_keeps_inflight_addr", 64'(bus.wr_burst_addr), 64'd1024);
    check("sync_burst_still_busy", 64'(busy), 64'd1);
    run_bursts(400);

    // 5: short burst flags len_err, which stays set through a normal burst
    do_reset();
    words_cfg = 63;
    push(1'b0, 24'h0);
    bus.wr_fifo_count = 10'd100;
    calib_done = 1'b1;
    wait_q_empty(50);
    check("len_err_before_finish", 64'(len_err), 64'd0);
    words_cfg = 64;
    push(1'b0, 24'd512);
    wait_q_empty(200);
    check("len_err_after_short", 64'(len_err), 64'd1);
    run_bursts(200);
    check("len_err_sticky", 64'(len_err), 64'd1);

    // 6: reset in the middle of a read burst
    do_reset();
    push(1'b1, 24'h0);
    push(1'b1, 24'd512);
    bus.rd_fifo_space = 10'd100;
    calib_done = 1'b1;
    wait_q_empty(300);
    repeat (20) step();
    @(negedge mem_clk);
    #2;
    check("pre_rst_rd_push_active", 64'(bus.rd_fifo_wr_en), 64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_rd_req", 64'(bus.rd_burst_req), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_rd_fifo_wr_en", 64'(bus.rd_fifo_wr_en), 64'd0);
    check("mid_rst_rd_addr", 64'(bus.rd_burst_addr), 64'd0);
    check("mid_rst_wr_addr", 64'(bus.wr_burst_addr), 64'd0);
    repeat (2) step();
    do_reset();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
